// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the ID/EX stages and the stall/flush sequencer.
// The decode/hazard/branch side drives requests; the sequencer drives
// the pipeline-register controls, status and performance counters.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid_inst;
  logic             id_illegal;
  logic             id_hazard;
  logic             id_is_mul;
  logic             id_is_ebreak;
  logic             ex_take_branch;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             mul_start;
  logic             mul_abort;
  logic             halted;
  logic             halt_illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid_inst, id_illegal, id_hazard, id_is_mul, id_is_ebreak,
           ex_take_branch,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mul_start,
           mul_abort, halted, halt_illegal, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid_inst, id_illegal, id_hazard, id_is_mul, id_is_ebreak,
           ex_take_branch,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, mul_start,
           mul_abort, halted, halt_illegal, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; branch flush, halt detect, hazard, MUL start
//   MUL_WAIT | MUL/MULHU held in ID until its latency has elapsed
//   DRAIN    | halt requested; inserting bubbles for DRAIN_DEPTH cycles
//   HALTED   | pipeline frozen until reset
//
// Controls are combinational from state, cnt and inputs and are forced
// low while reset is asserted.
module pipeline_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, DRAIN, HALTED} state_e;

  localparam logic [3:0]       MUL_CNT_INIT   = 4'(MUL_LATENCY - 1);
  localparam logic [3:0]       DRAIN_CNT_INIT = 4'(DRAIN_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             halt_illegal_q, halt_illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c;
  logic mul_start_c, mul_abort_c;
  logic flush_inc;
  logic halt_req;

  // An illegal instruction halts regardless of the valid qualifier on ID;
  // EBREAK only when it is a real instruction.
  assign halt_req = bus.id_illegal | (bus.id_valid_inst & bus.id_is_ebreak);

  // Next-state, down-counter and control decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    halt_illegal_d = halt_illegal_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    mul_start_c    = 1'b0;
    mul_abort_c    = 1'b0;
    flush_inc      = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_take_branch) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          flush_inc      = 1'b1;
        end else if (halt_req) begin
          pc_stall_c     = 1'b1;
          if_id_flush_c  = 1'b1;
          // EBREAK itself proceeds into ID/EX; an illegal op must not.
          id_ex_bubble_c = bus.id_illegal;
          state_d        = DRAIN;
          cnt_d          = DRAIN_CNT_INIT;
          if (bus.id_illegal) halt_illegal_d = 1'b1;
        end else if (bus.id_hazard) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (bus.id_valid_inst && bus.id_is_mul) begin
          mul_start_c    = 1'b1;
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          state_d        = MUL_WAIT;
          cnt_d          = MUL_CNT_INIT;
        end
      end

      MUL_WAIT: begin
        if (bus.ex_take_branch) begin
          // The MUL sits behind a taken branch, so it is on the wrong path.
          mul_abort_c    = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          flush_inc      = 1'b1;
          state_d        = RUN;
        end else if (cnt_q != 4'd0) begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          cnt_d          = cnt_q - 4'd1;
        end else begin
          state_d        = RUN;
        end
      end

      DRAIN: begin
        pc_stall_c    = 1'b1;
        if_id_flush_c = 1'b1;
        if (cnt_q == 4'd0) state_d = HALTED;
        else               cnt_d   = cnt_q - 4'd1;
      end

      HALTED: begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end

      default: state_d = RUN;
    endcase
  end

  // Saturating performance counters; HALTED stalls are not charged.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (if_id_stall_c && (state_q != HALTED) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_inc && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // State, counter and sticky-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      cnt_q          <= 4'd0;
      halt_illegal_q <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      halt_illegal_q <= halt_illegal_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.pc_stall     = rst & pc_stall_c;
  assign bus.if_id_stall  = rst & if_id_stall_c;
  assign bus.if_id_flush  = rst & if_id_flush_c;
  assign bus.id_ex_bubble = rst & id_ex_bubble_c;
  assign bus.mul_start    = rst & mul_start_c;
  assign bus.mul_abort    = rst & mul_abort_c;
  assign bus.halted       = rst & (state_q == HALTED);
  assign bus.halt_illegal = halt_illegal_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
